// File: rtl/bht_scheduler.sv
// Branch-history-table controller: one table port shared between fetch lookups
// and queued resolve-side counter updates.
module bht_scheduler #(
    parameter int         IDX_W    = 4,
    parameter int         UQ_DEPTH = 4,
    parameter logic [1:0] INIT_CTR = 2'd3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        lk_valid,
    input  logic [IDX_W-1:0]            lk_idx,
    output logic                        lk_ready,
    output logic                        pred_valid,
    output logic                        pred_taken,
    output logic [1:0]                  pred_ctr,
    input  logic                        up_valid,
    input  logic [IDX_W-1:0]            up_idx,
    input  logic                        up_taken,
    output logic                        up_ready,
    output logic [$clog2(UQ_DEPTH):0]   uq_count
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int PTR_W   = $clog2(UQ_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_LOOKUP,
        SLOT_DRAIN
    } slot_e;

    logic [1:0]       ctr_tbl [ENTRIES];
    logic [IDX_W-1:0] uq_idx  [UQ_DEPTH];
    logic             uq_tkn  [UQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    slot_e            slot;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_idx;
    logic             head_tkn;
    logic [1:0]       head_ctr;
    logic [1:0]       head_ctr_next;
    logic [1:0]       lk_ctr;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'd3)
            res = ctr + 2'd1;
        else if (!taken && ctr != 2'd0)
            res = ctr - 2'd1;
        return res;
    endfunction

    assign full  = (uq_count == CNT_W'(UQ_DEPTH));
    assign empty = (uq_count == '0);

    // Ready depends only on FIFO occupancy so neither side waits on the other.
    assign lk_ready = !full;
    assign up_ready = !full;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        slot = SLOT_IDLE;
        if (full)
            slot = SLOT_DRAIN;
        else if (lk_valid)
            slot = SLOT_LOOKUP;
        else if (!empty)
            slot = SLOT_DRAIN;
    end

    assign push          = up_valid && !full;
    assign pop           = (slot == SLOT_DRAIN);
    assign head_idx      = uq_idx[rd_ptr];
    assign head_tkn      = uq_tkn[rd_ptr];
    assign head_ctr      = ctr_tbl[head_idx];
    assign head_ctr_next = sat_update(head_ctr, head_tkn);
    assign lk_ctr        = ctr_tbl[lk_idx];

    // NOTE: the counter table must come out of reset at INIT_CTR, so it is a
    // reset flop array; the FIFO payload below is gated by uq_count and needs no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr_tbl[i] <= INIT_CTR;
        end else if (slot == SLOT_DRAIN) begin
            ctr_tbl[head_idx] <= head_ctr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            uq_idx[wr_ptr] <= up_idx;
            uq_tkn[wr_ptr] <= up_taken;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            uq_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   uq_count <= uq_count + CNT_W'(1);
                2'b01:   uq_count <= uq_count - CNT_W'(1);
                default: uq_count <= uq_count;
            endcase
        end
    end

    // Prediction reads the committed table value before any drain write at this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_ctr   <= 2'd0;
        end else begin
            pred_valid <= (slot == SLOT_LOOKUP);
            if (slot == SLOT_LOOKUP) begin
                pred_taken <= lk_ctr[1];
                pred_ctr   <= lk_ctr;
            end
        end
    end

endmodule

// File: tb/tb_bht_scheduler.sv
// Directed, table-driven bench for bht_scheduler: each vector is one clock cycle
// of stimulus with hand-computed ready, prediction and occupancy values.
module tb_bht_scheduler;

    localparam int IDX_W    = 4;
    localparam int UQ_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_ready;
    logic             pred_valid;
    logic             pred_taken;
    logic [1:0]       pred_ctr;
    logic             up_valid;
    logic [IDX_W-1:0] up_idx;
    logic             up_taken;
    logic             up_ready;
    logic [2:0]       uq_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       lk_v;
        int         lk_i;
        logic       up_v;
        int         up_i;
        logic       up_t;
        logic       e_rdy;
        logic       e_pv;
        logic [1:0] e_ctr;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t post_vecs[$];

    bht_scheduler #(
        .IDX_W    (IDX_W),
        .UQ_DEPTH (UQ_DEPTH),
        .INIT_CTR (2'd3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lk_valid   (lk_valid),
        .lk_idx     (lk_idx),
        .lk_ready   (lk_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ctr   (pred_ctr),
        .up_valid   (up_valid),
        .up_idx     (up_idx),
        .up_taken   (up_taken),
        .up_ready   (up_ready),
        .uq_count   (uq_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic vec_t v(input logic lk_v, input int lk_i, input logic up_v, input int up_i,
                               input logic up_t, input logic e_rdy, input logic e_pv,
                               input logic [1:0] e_ctr, input int e_cnt);
        vec_t r;
        r.lk_v = lk_v; r.lk_i = lk_i; r.up_v = up_v; r.up_i = up_i; r.up_t = up_t;
        r.e_rdy = e_rdy; r.e_pv = e_pv; r.e_ctr = e_ctr; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic drive_idle();
        lk_valid = 1'b0;
        lk_idx   = '0;
        up_valid = 1'b0;
        up_idx   = '0;
        up_taken = 1'b0;
    endtask

    // Drive at the falling edge, check readies before the rising edge,
    // check registered outputs 1 time unit after it.
    task automatic apply(input vec_t t, input int step);
        string tag;
        @(negedge clk);
        lk_valid = t.lk_v;
        lk_idx   = IDX_W'(t.lk_i);
        up_valid = t.up_v;
        up_idx   = IDX_W'(t.up_i);
        up_taken = t.up_t;
        #1;
        tag = $sformatf("step%0d", step);
        check({tag, " lk_ready"}, int'(lk_ready), int'(t.e_rdy));
        check({tag, " up_ready"}, int'(up_ready), int'(t.e_rdy));
        @(posedge clk);
        #1;
        check({tag, " pred_valid"}, int'(pred_valid), int'(t.e_pv));
        check({tag, " pred_ctr"},   int'(pred_ctr),   int'(t.e_ctr));
        check({tag, " pred_taken"}, int'(pred_taken), int'(t.e_ctr[1]));
        check({tag, " uq_count"},   int'(uq_count),   t.e_cnt);
    endtask

    initial begin
        //                 lk idx up idx tk  rdy pv ctr cnt
        // reset value, then hold of pred outputs
        vecs.push_back(v(1, 5,  0, 0,  0,  1, 1, 3, 0));
        vecs.push_back(v(0, 0,  0, 0,  0,  1, 0, 3, 0));
        // four not-taken updates to idx 2: 3->2->1->0->0
        vecs.push_back(v(0, 0,  1, 2,  0,  1, 0, 3, 1));
        vecs.push_back(v(0, 0,  1, 2,  0,  1, 0, 3, 1));
        vecs.push_back(v(0, 0,  1, 2,  0,  1, 0, 3, 1));
        vecs.push_back(v(0, 0,  1, 2,  0,  1, 0, 3, 1));
        vecs.push_back(v(0, 0,  0, 0,  0,  1, 0, 3, 0));
        vecs.push_back(v(1, 2,  0, 0,  0,  1, 1, 0, 0));
        // fifth not-taken saturates at 0, then two taken -> 2
        vecs.push_back(v(0, 0,  1, 2,  0,  1, 0, 0, 1));
        vecs.push_back(v(0, 0,  0, 0,  0,  1, 0, 0, 0));
        vecs.push_back(v(0, 0,  1, 2,  1,  1, 0, 0, 1));
        vecs.push_back(v(0, 0,  1, 2,  1,  1, 0, 0, 1));
        vecs.push_back(v(0, 0,  0, 0,  0,  1, 0, 0, 0));
        vecs.push_back(v(1, 2,  0, 0,  0,  1, 1, 2, 0));
        vecs.push_back(v(1, 0,  0, 0,  0,  1, 1, 3, 0));
        // no forwarding: same-edge lookup sees old value
        vecs.push_back(v(1, 7,  1, 7,  0,  1, 1, 3, 1));
        vecs.push_back(v(0, 0,  0, 0,  0,  1, 0, 3, 0));
        vecs.push_back(v(1, 7,  0, 0,  0,  1, 1, 2, 0));
        // fill to 2 behind lookups, then push+pop together
        vecs.push_back(v(1, 0,  1, 9,  0,  1, 1, 3, 1));
        vecs.push_back(v(1, 9,  1, 9,  1,  1, 1, 3, 2));
        vecs.push_back(v(0, 0,  1, 10, 0,  1, 0, 3, 2));
        vecs.push_back(v(1, 9,  0, 0,  0,  1, 1, 2, 2));
        vecs.push_back(v(0, 0,  0, 0,  0,  1, 0, 2, 1));
        vecs.push_back(v(0, 0,  0, 0,  0,  1, 0, 2, 0));
        vecs.push_back(v(1, 10, 0, 0,  0,  1, 1, 2, 0));
        vecs.push_back(v(1, 9,  0, 0,  0,  1, 1, 3, 0));
        // continuous lookups fill the FIFO; one drain per full cycle
        vecs.push_back(v(1, 1,  1, 12, 0,  1, 1, 3, 1));
        vecs.push_back(v(1, 1,  1, 12, 0,  1, 1, 3, 2));
        vecs.push_back(v(1, 1,  1, 12, 0,  1, 1, 3, 3));
        vecs.push_back(v(1, 1,  1, 13, 0,  1, 1, 3, 4));
        vecs.push_back(v(1, 12, 1, 14, 0,  0, 0, 3, 3));
        vecs.push_back(v(1, 12, 1, 14, 0,  1, 1, 2, 4));
        vecs.push_back(v(1, 12, 0, 0,  0,  0, 0, 2, 3));
        vecs.push_back(v(1, 12, 0, 0,  0,  1, 1, 1, 3));
        vecs.push_back(v(0, 0,  0, 0,  0,  1, 0, 1, 2));
        vecs.push_back(v(0, 0,  0, 0,  0,  1, 0, 1, 1));
        vecs.push_back(v(0, 0,  0, 0,  0,  1, 0, 1, 0));
        vecs.push_back(v(1, 12, 0, 0,  0,  1, 1, 0, 0));
        vecs.push_back(v(1, 14, 0, 0,  0,  1, 1, 2, 0));
        vecs.push_back(v(1, 13, 0, 0,  0,  1, 1, 2, 0));
        // queue three updates to idx 3 behind lookups before the async reset
        vecs.push_back(v(1, 4,  1, 3,  0,  1, 1, 3, 1));
        vecs.push_back(v(1, 4,  1, 3,  0,  1, 1, 3, 2));
        vecs.push_back(v(1, 4,  1, 3,  0,  1, 1, 3, 3));

        // after the mid-queue reset every counter is back at 3
        post_vecs.push_back(v(1, 3,  0, 0, 0,  1, 1, 3, 0));
        post_vecs.push_back(v(1, 12, 0, 0, 0,  1, 1, 3, 0));
        post_vecs.push_back(v(1, 2,  0, 0, 0,  1, 1, 3, 0));

        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst pred_valid", int'(pred_valid), 0);
        check("rst pred_taken", int'(pred_taken), 0);
        check("rst pred_ctr",   int'(pred_ctr),   0);
        check("rst uq_count",   int'(uq_count),   0);
        check("rst lk_ready",   int'(lk_ready),   1);
        check("rst up_ready",   int'(up_ready),   1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            apply(vecs[i], i);

        // asynchronous reset between edges while three updates are queued
        #2;
        rst_n = 1'b0;
        #1;
        check("async pred_valid", int'(pred_valid), 0);
        check("async pred_ctr",   int'(pred_ctr),   0);
        check("async pred_taken", int'(pred_taken), 0);
        check("async uq_count",   int'(uq_count),   0);
        check("async lk_ready",   int'(lk_ready),   1);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (post_vecs[i])
            apply(post_vecs[i], 100 + i);

        @(negedge clk);
        drive_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
